// File: rtl/lib_cpu_pkg.sv
// rtl/lib_cpu_pkg.sv - shared types and constants for the 4-bit CPU instruction path
//
// Contents:
//   IMEM_DEPTH     number of program memory words addressable by the 4-bit ip
//   inst_t         instruction word layout: op[7:4], imm[3:0]
//   loader_state_t program loader FSM states
//   inst_pack      helper that builds an instruction byte from opcode and immediate

package lib_cpu;

    localparam int IMEM_DEPTH = 16;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] imm;
    } inst_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        CHECK   = 2'd2,
        RELEASE = 2'd3
    } loader_state_t;

    function automatic inst_t inst_pack(input logic [3:0] op, input logic [3:0] imm);
        inst_t r;
        r.op  = op;
        r.imm = imm;
        return r;
    endfunction

endpackage

// File: rtl/prog_loader_mem.sv
// rtl/prog_loader_mem.sv - 16 x W program memory, one sync write port, one async read port
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset; clears every word to zero
//   we     in   write enable, sampled on the rising clock edge
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational; shows the old word during a same-cycle write

module prog_mem
    import lib_cpu::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [3:0]   waddr,
    input  logic [W-1:0] wdata,
    input  logic [3:0]   raddr,
    output logic [W-1:0] rdata
);

    logic [W-1:0] mem [IMEM_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader and instruction server for the 4-bit CPU
//
// Optional feature macro: PROG_LOADER_CSUM_EN (trailing checksum byte, sticky err on mismatch).
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   load_start  in   single-cycle request to begin (or restart) a load session
//   in_valid    in   input byte valid
//   in_data     in   input byte
//   in_ready    out  loader accepts a byte this cycle (registered)
//   cpu_ip      in   CPU instruction pointer
//   cpu_inst    out  mem[cpu_ip], combinational
//   cpu_hold    out  CPU must not update its registers while high (registered)
//   cpu_ip_clr  out  one-cycle pulse forcing the CPU ip to 0 on release (registered)
//   done        out  one-cycle pulse on successful session completion (registered)
//   err         out  sticky checksum error, cleared by load_start; tied 0 without the feature

module prog_loader
    import lib_cpu::*;
#(
    parameter int IMEM_WORDS = 16,
    parameter int INST_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    output logic              in_ready,
    input  logic [3:0]        cpu_ip,
    output logic [INST_W-1:0] cpu_inst,
    output logic              cpu_hold,
    output logic              cpu_ip_clr,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] LAST_ADDR = 4'(IMEM_WORDS - 1);

    loader_state_t state;
    logic [3:0]    addr;
    logic          xfer;
    logic          mem_we;

    assign xfer = in_valid && in_ready;

    // A restart request wins over a byte presented in the same cycle, so
    // that byte is dropped rather than written at the stale address.
    assign mem_we = xfer && (state == LOAD) && !load_start;

`ifdef PROG_LOADER_CSUM_EN
    logic [INST_W-1:0] sum;
    logic [INST_W-1:0] sum_next;
    logic              err_q;

    assign sum_next = sum + in_data;
    assign err      = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            in_ready   <= 1'b0;
            cpu_hold   <= 1'b0;
            cpu_ip_clr <= 1'b0;
            done       <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            sum        <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            done       <= 1'b0;
            cpu_ip_clr <= 1'b0;
            case (state)
                IDLE: begin
                    // After a checksum failure cpu_hold is still 1 here and
                    // stays so until the next session starts.
                    if (load_start) begin
                        state    <= LOAD;
                        addr     <= '0;
                        in_ready <= 1'b1;
                        cpu_hold <= 1'b1;
`ifdef PROG_LOADER_CSUM_EN
                        sum      <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        addr <= '0;
`ifdef PROG_LOADER_CSUM_EN
                        sum  <= '0;
`endif
                    end else if (xfer) begin
                        addr <= addr + 4'd1;
`ifdef PROG_LOADER_CSUM_EN
                        sum  <= sum_next;
`endif
                        if (addr == LAST_ADDR) begin
`ifdef PROG_LOADER_CSUM_EN
                            state      <= CHECK;
`else
                            state      <= RELEASE;
                            in_ready   <= 1'b0;
                            done       <= 1'b1;
                            cpu_ip_clr <= 1'b1;
`endif
                        end
                    end
                end
                CHECK: begin
`ifdef PROG_LOADER_CSUM_EN
                    if (load_start) begin
                        state <= LOAD;
                        addr  <= '0;
                        sum   <= '0;
                    end else if (xfer) begin
                        // Checksum byte is consumed but never stored.
                        in_ready <= 1'b0;
                        if (sum_next == '0) begin
                            state      <= RELEASE;
                            done       <= 1'b1;
                            cpu_ip_clr <= 1'b1;
                        end else begin
                            state <= IDLE;
                            err_q <= 1'b1;
                        end
                    end
`else
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
`endif
                end
                RELEASE: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

    prog_mem #(
        .W (INST_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (addr),
        .wdata (in_data),
        .raddr (cpu_ip),
        .rdata (cpu_inst)
    );

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 4-bit CPU's instruction path: accepts a byte stream and fills a 16-entry x 8-bit program memory.
- Holds the CPU in halt while loading, then releases it with ip restarting at 0.
- Serves the CPU's combinational instruction read (ip -> opcode/imm) from the same memory.
- Sits between the board-level byte source (switch/serial front end) and the CPU core.

Parameters:
- IMEM_WORDS, 16, number of program words loaded per session; legal range 1..16 (ip is 4 bits).
- INST_W, 8, instruction width: opcode[7:4], imm[3:0].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle request to begin a load session
- in_valid  in  1  input byte valid
- in_data  in  INST_W  input byte
- in_ready  out  1  loader can accept a byte this cycle
- cpu_ip  in  4  CPU instruction pointer
- cpu_inst  out  INST_W  instruction at cpu_ip, combinational read
- cpu_hold  out  1  CPU must not update REGS while high
- cpu_ip_clr  out  1  one-cycle pulse forcing CPU ip to 0 on release
- done  out  1  pulses 1 cycle when a load session completes successfully
- err  out  1  sticky error flag, cleared by next load_start

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, all memory words=8'h00, addr counter=0.
  - in_ready=0, cpu_hold=0, cpu_ip_clr=0, done=0, err=0.
- States: IDLE, LOAD, CHECK (feature only), RELEASE.
- IDLE:
  - in_ready=0; CPU runs (cpu_hold=0).
  - load_start=1 -> LOAD, addr=0, err=0, cpu_hold=1 from the next cycle.
- LOAD:
  - in_ready=1, cpu_hold=1.
  - Transfer occurs when in_valid && in_ready: mem[addr]<=in_data, addr<=addr+1.
  - The transfer that writes addr==IMEM_WORDS-1 goes to RELEASE, or to CHECK with the feature.
  - in_valid while in_ready=0 is ignored; the source holds the byte.
  - load_start during LOAD restarts: addr=0. Already-written words stay stale until overwritten.
- RELEASE: one cycle.
  - cpu_ip_clr=1, done=1, cpu_hold=1.
  - Next cycle -> IDLE with cpu_hold=0; CPU fetches mem[0] first.
- Address counter is 4 bits. Words at addr >= IMEM_WORDS are never written and keep their reset/previous value.
- cpu_inst=mem[cpu_ip] at all times, including during LOAD. The CPU is held, so this has no architectural effect.
- Same-cycle write and read of one address: cpu_inst shows the old value until the clock edge (write-first is not required).
- Reset asserted mid-LOAD: the session aborts and memory clears to zeros; the CPU then runs an all-zero program.
- Output latency: every control output is registered except cpu_inst.

Optional Feature:
- Macro: PROG_LOADER_CSUM_EN.
- Defined:
  - After the last program byte, state CHECK accepts one extra byte (in_ready=1) as a checksum; it is not stored.
  - Running 8-bit sum of all program bytes + checksum, mod 256, == 0 -> RELEASE.
  - Otherwise err=1, no done, no cpu_ip_clr, -> IDLE with cpu_hold kept 1 until the next load_start.
  - The running sum resets on load_start.
- Undefined:
  - No CHECK state, no sum register; err is tied 0.

Decomposition:
- Shared package lib_cpu gains:
  - typedef INST {logic [3:0] op; logic [3:0] imm;}
  - LOADER_STATE enum {IDLE, LOAD, CHECK, RELEASE}
  - constant IMEM_DEPTH=16
- Natural sub-module: prog_mem, a 16x8 storage with one synchronous write port and one asynchronous read port, with async clear on rst_n.
- FSM, counter and checksum stay in prog_loader.

Test Plan:
- Reset then idle: cpu_ip=0..15 -> cpu_inst=8'h00 everywhere; cpu_hold=0, in_ready=0, err=0.
- load_start, 16 back-to-back bytes 8'h30..8'h3F -> cpu_hold high throughout; done and cpu_ip_clr pulse 1 cycle after the 16th byte; then cpu_ip=5 -> cpu_inst=8'h35.
- Same load with in_valid toggling every other cycle -> identical memory contents; exactly 16 writes; done only after the 16th transfer.
- load_start after 7 bytes, then 16 bytes 8'hA0..8'hAF -> mem[0..15]=8'hA0..8'hAF; a single done pulse.
- rst_n low after 9 bytes -> all outputs at reset values immediately (async); memory reads 8'h00.
- PROG_LOADER_CSUM_EN, bytes 8'h01 x16 then checksum 8'hF0 -> done. Repeat with checksum 8'hF1 -> err=1, no done, cpu_hold stays 1.
